dm_store_buffer: RTL and testbench

Posted-write store buffer between the MEM-stage store/load logic and the data memory. Stores from MEM are queued in a small in-order FIFO and retired into the data memory one per cycle. Retirement happens only in cycles when the shared memory port is not used by a load. Loads from MEM search the buffer: they take the youngest matching full-word store, or stall until a matching partial store has drained.

---
 rtl/dm_store_buffer.sv | 132 +++++++++++++
 tb/tb_dm_store_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_buffer
// Brief    : In-order posted-write store FIFO in front of the data memory,
//            with load forwarding from full-word stores and load blocking
//            on partial-store matches.
// Revision : 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_sh,
    input  logic        st_sb,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        st_ready,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        empty,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_sh,
    output logic        dm_sb,
    output logic [31:0] dm_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic             sh_q   [DEPTH];
    logic             sb_q   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_drain;
    logic             w_blocked;
    logic             w_match;
    logic             w_match_part;
    logic [31:0]      w_match_data;
    logic [PTR_W-1:0] w_idx;
    logic             ld_addr_lo_unused;

    assign ld_addr_lo_unused = ^ld_addr[1:0];

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_enq   = st_valid & ~w_full & ~reset;

    // Walk oldest to youngest so the last hit left standing is the youngest match.
    always_comb begin
        w_match      = 1'b0;
        w_match_part = 1'b0;
        w_match_data = '0;
        w_idx        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[w_idx][31:2] == ld_addr[31:2])) begin
                w_match      = 1'b1;
                w_match_part = sh_q[w_idx] | sb_q[w_idx];
                w_match_data = data_q[w_idx];
            end
        end
    end

    assign w_blocked = ld_valid & w_match & w_match_part;
    assign w_drain   = ~w_empty & ~reset & (~ld_valid | w_blocked);

    assign st_ready = ~w_full;
    assign empty    = w_empty;
    assign ld_hit   = ld_valid & w_match & ~w_match_part;
    assign ld_data  = ld_hit ? w_match_data : 32'h0;
    assign stall    = (st_valid & w_full) | w_blocked;

    assign dm_we    = w_drain;
    assign dm_addr  = addr_q[head_q];
    assign dm_wd    = data_q[head_q];
    assign dm_sh    = sh_q[head_q];
    assign dm_sb    = sb_q[head_q];
    assign dm_pc    = pc_q[head_q];

    always_comb begin
        head_d  = w_drain ? head_q + 1'b1 : head_q;
        tail_d  = w_enq   ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({w_enq, w_drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            sh_q[tail_q]   <= st_sh;
            sb_q[tail_q]   <= st_sb;
            pc_q[tail_q]   <= st_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_store_buffer
// Brief    : Self-checking bench for dm_store_buffer: write scoreboard,
//            table-driven load forwarding vectors and multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset, st_valid, st_sh, st_sb, ld_valid;
    logic [31:0] st_addr, st_data, st_pc, ld_addr;
    logic        st_ready, ld_hit, stall, empty, dm_we, dm_sh, dm_sb;
    logic [31:0] ld_data, dm_addr, dm_wd, dm_pc;

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_sh(st_sh), .st_sb(st_sb), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .st_ready(st_ready), .ld_hit(ld_hit), .ld_data(ld_data),
        .stall(stall), .empty(empty),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_sh(dm_sh), .dm_sb(dm_sb), .dm_pc(dm_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        sh;
        logic        sb;
        logic [31:0] pc;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] ld_addr;
        logic        exp_hit;
        logic [31:0] exp_data;
        logic        exp_stall;
    } ldvec_t;

    wr_t         wq[$];
    wr_t         e;
    logic [31:0] mem [0:1023];
    logic [31:0] pc_ctr = 32'h1000;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Memory image built from what the DUT actually writes; scoreboard checks order and fields.
    always @(negedge clk) begin
        logic [31:0] w;
        #2;
        if (dm_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got write to 0x%08h expected none", dm_addr);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", dm_addr, e.addr);
                chk("wr_data", dm_wd, e.data);
                chk("wr_sh", {31'b0, dm_sh}, {31'b0, e.sh});
                chk("wr_sb", {31'b0, dm_sb}, {31'b0, e.sb});
                chk("wr_pc", dm_pc, e.pc);
            end
            w = mem[dm_addr[11:2]];
            if (dm_sb)      w[{dm_addr[1:0], 3'b000} +: 8] = dm_wd[7:0];
            else if (dm_sh) w[{dm_addr[1], 4'b0000} +: 16] = dm_wd[15:0];
            else            w = dm_wd;
            mem[dm_addr[11:2]] = w;
        end
    end

    task automatic drive_zero();
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        st_sh = 1'b0; st_sb = 1'b0; st_pc = '0; ld_valid = 1'b0; ld_addr = '0;
    endtask

    task automatic idle();
        @(negedge clk);
        drive_zero();
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive_zero();
            reset = 1'b1;
            wq.delete();
            #1;
            chk("reset_dm_we", {31'b0, dm_we}, 32'h0);
        end
    endtask

    // hold=1 keeps a non-matching load on the port so queued stores accumulate.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic h, input logic b, input logic hold);
        int  waited;
        wr_t w;
        @(negedge clk);
        drive_zero();
        st_valid = 1'b1; st_addr = a; st_data = d; st_sh = h; st_sb = b; st_pc = pc_ctr;
        ld_valid = hold; ld_addr = 32'h400;
        #1;
        waited = 0;
        while (stall === 1'b1 && waited < 16) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 16) begin
            n_cmp++;
            n_err++;
            $display("FAIL store_accept_timeout: got stall after %0d cycles expected acceptance", waited);
        end else begin
            w.addr = a; w.data = d; w.sh = h; w.sb = b; w.pc = pc_ctr;
            wq.push_back(w);
        end
        pc_ctr += 4;
    endtask

    task automatic blocked_load(input logic [31:0] a, input int exp_cycles, input string nm);
        int n;
        @(negedge clk);
        drive_zero();
        ld_valid = 1'b1; ld_addr = a;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 16) begin
            chk({nm, "_hit_while_blocked"}, {31'b0, ld_hit}, 32'h0);
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_stall_cycles"}, n, exp_cycles);
        chk({nm, "_hit_after"}, {31'b0, ld_hit}, 32'h0);
        chk({nm, "_data_after"}, ld_data, 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ldvec_t vt[7];
        wr_t    w;
        vt[0] = '{"fwd_youngest_0x22", 32'h22,  1'b1, 32'h22222222, 1'b0};
        vt[1] = '{"fwd_youngest_0x20", 32'h20,  1'b1, 32'h22222222, 1'b0};
        vt[2] = '{"fwd_0x40",          32'h40,  1'b1, 32'h33333333, 1'b0};
        vt[3] = '{"fwd_0x43",          32'h43,  1'b1, 32'h33333333, 1'b0};
        vt[4] = '{"miss_0x60",         32'h60,  1'b0, 32'h0,        1'b0};
        vt[5] = '{"miss_0x400",        32'h400, 1'b0, 32'h0,        1'b0};
        vt[6] = '{"miss_0x24",         32'h24,  1'b0, 32'h0,        1'b0};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        drive_zero();
        reset = 1'b1;
        apply_reset(2);

        idle();
        chk("rst_empty", {31'b0, empty}, 32'h1);
        chk("rst_st_ready", {31'b0, st_ready}, 32'h1);
        chk("rst_dm_we", {31'b0, dm_we}, 32'h0);
        chk("rst_ld_hit", {31'b0, ld_hit}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // Single sw: written the cycle after enqueue.
        do_store(32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sw_dm_we", {31'b0, dm_we}, 32'h1);
        chk("sw_dm_addr", dm_addr, 32'h10);
        chk("sw_dm_wd", dm_wd, 32'hDEADBEEF);
        idle();
        chk("sw_empty_after", {31'b0, empty}, 32'h1);
        chk("sw_dm_we_after", {31'b0, dm_we}, 32'h0);

        // Fill to DEPTH, then a fifth store waits for the first drain.
        for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_zero();
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h55555555; st_pc = pc_ctr;
        ld_valid = 1'b1; ld_addr = 32'h400;
        #1;
        chk("full_stall", {31'b0, stall}, 32'h1);
        chk("full_st_ready", {31'b0, st_ready}, 32'h0);
        chk("full_dm_we_held", {31'b0, dm_we}, 32'h0);
        @(negedge clk);
        ld_valid = 1'b0; ld_addr = '0;
        #1;
        chk("full_drain_stall", {31'b0, stall}, 32'h1);
        chk("full_drain_we", {31'b0, dm_we}, 32'h1);
        chk("full_drain_addr", dm_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("full_accept_stall", {31'b0, stall}, 32'h0);
        chk("full_accept_ready", {31'b0, st_ready}, 32'h1);
        chk("full_accept_addr", dm_addr, 32'h4);
        w.addr = 32'h10; w.data = 32'h55555555; w.sh = 1'b0; w.sb = 1'b0; w.pc = pc_ctr;
        wq.push_back(w);
        pc_ctr += 4;
        idle();
        chk("wrap_addr_8", dm_addr, 32'h8);
        idle();
        chk("wrap_addr_c", dm_addr, 32'hC);
        idle();
        chk("wrap_addr_fifth", dm_addr, 32'h10);
        chk("wrap_wd_fifth", dm_wd, 32'h55555555);
        idle();
        chk("wrap_empty", {31'b0, empty}, 32'h1);

        // Forwarding table against a full buffer.
        do_store(32'h20, 32'h11111111, 1'b0, 1'b0, 1'b1);
        do_store(32'h20, 32'h22222222, 1'b0, 1'b0, 1'b1);
        do_store(32'h40, 32'h33333333, 1'b0, 1'b0, 1'b1);
        do_store(32'h51, 32'h00000077, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_zero();
            ld_valid = 1'b1; ld_addr = vt[i].ld_addr;
            #1;
            chk({vt[i].name, "_hit"}, {31'b0, ld_hit}, {31'b0, vt[i].exp_hit});
            chk({vt[i].name, "_data"}, ld_data, vt[i].exp_data);
            chk({vt[i].name, "_stall"}, {31'b0, stall}, {31'b0, vt[i].exp_stall});
            chk({vt[i].name, "_st_ready"}, {31'b0, st_ready}, 32'h0);
        end
        // Youngest entry is the partial match: every entry must drain first.
        blocked_load(32'h50, 4, "blk_youngest");
        chk("blk_youngest_empty", {31'b0, empty}, 32'h1);
        idle();
        chk("blk_youngest_mem", mem[32'h50 >> 2], 32'h00007700);

        // sw then sb to the same word, load blocks for two drains.
        do_store(32'h30, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1);
        do_store(32'h31, 32'h00000055, 1'b0, 1'b1, 1'b1);
        blocked_load(32'h30, 2, "blk_partial");
        idle();
        chk("blk_partial_mem", mem[32'h30 >> 2], 32'hAABB55DD);

        // Reset with three stores queued discards them all.
        do_store(32'h200, 32'h1, 1'b0, 1'b0, 1'b1);
        do_store(32'h204, 32'h2, 1'b0, 1'b0, 1'b1);
        do_store(32'h208, 32'h3, 1'b0, 1'b0, 1'b1);
        apply_reset(1);
        idle();
        chk("midrst_empty", {31'b0, empty}, 32'h1);
        chk("midrst_st_ready", {31'b0, st_ready}, 32'h1);
        chk("midrst_dm_we", {31'b0, dm_we}, 32'h0);
        idle();
        idle();

        // Enqueue and drain in the same cycle at count=2.
        do_store(32'h100, 32'h1, 1'b0, 1'b0, 1'b1);
        do_store(32'h104, 32'h2, 1'b0, 1'b0, 1'b1);
        do_store(32'h108, 32'h3, 1'b0, 1'b0, 1'b0);
        chk("simul_we", {31'b0, dm_we}, 32'h1);
        chk("simul_oldest", dm_addr, 32'h100);
        chk("simul_stall", {31'b0, stall}, 32'h0);
        idle();
        chk("simul_next_104", dm_addr, 32'h104);
        chk("simul_not_empty1", {31'b0, empty}, 32'h0);
        idle();
        chk("simul_next_108", dm_addr, 32'h108);
        chk("simul_not_empty2", {31'b0, empty}, 32'h0);
        idle();
        chk("simul_empty", {31'b0, empty}, 32'h1);
        chk("simul_we_off", {31'b0, dm_we}, 32'h0);

        idle();
        chk("scoreboard_drained", wq.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
